msg_block_loader: RTL and testbench

MSG_BLOCK_LOADER -- requirements
Module: msg_block_loader

---
 rtl/msg_block_loader.sv | 106 ++++++++++
 tb/tb_msg_block_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_block_loader.sv
// msg_block_loader: collects WORDS 32-bit message words into one block.
//   clock, reset_n      : clock, async active-low reset
//   clear               : synchronous abort of a partial or held block
//   in_valid/in_ready   : word stream (in_ready registered, no input path)
//   in_word             : word written into slot word_count
//   block_valid/ready   : block handshake; block_out holds while valid
//   block_out           : assembled block, word 0 in the top 32 bits
//   word_count          : words stored in the current block (0..WORDS)

// One 32-bit block slot; loads d when we is set, otherwise holds.
module msg_block_slot (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        we,
  input  logic [31:0] d,
  output logic [31:0] q
);
  logic [31:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (we) data_d = d;
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) data_q <= '0;
    else          data_q <= data_d;

  assign q = data_q;
endmodule

module msg_block_loader #(
  parameter int WORDS = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_word,
  output logic                    block_valid,
  input  logic                    block_ready,
  output logic [32*WORDS-1:0]     block_out,
  output logic [$clog2(WORDS):0]  word_count
);
  localparam int CW = $clog2(WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    accept;
  logic [WORDS-1:0]        slot_we;
  logic [WORDS-1:0][31:0]  slot_q;

  // clear suppresses the slot write as well as the count update
  assign accept = in_valid && (state_q == FILL) && !clear;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = FILL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FILL: if (in_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = FULL;
        end
        default: if (block_ready) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end

  // 1-to-WORDS demux: only the slot addressed by the count is written
  for (genvar k = 0; k < WORDS; k++) begin : g_slot
    assign slot_we[k] = accept && (cnt_q == CW'(k));
    msg_block_slot u_slot (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (slot_we[k]),
      .d       (in_word),
      .q       (slot_q[k])
    );
    assign block_out[32*(WORDS-k)-1 -: 32] = slot_q[k];
  end

  assign in_ready    = (state_q == FILL);
  assign block_valid = (state_q == FULL);
  assign word_count  = cnt_q;
endmodule

// File: tb/tb_msg_block_loader.sv
module tb_msg_block_loader;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  // WORDS=16 instance
  logic         reset_n, clear, in_valid, block_ready;
  logic [31:0]  in_word;
  logic         in_ready, block_valid;
  logic [511:0] block_out;
  logic [4:0]   word_count;

  // WORDS=4 instance
  logic         reset_n4, clear4, in_valid4, block_ready4;
  logic [31:0]  in_word4;
  logic         in_ready4, block_valid4;
  logic [127:0] block_out4;
  logic [2:0]   word_count4;

  msg_block_loader #(.WORDS(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_word(in_word), .block_valid(block_valid),
    .block_ready(block_ready), .block_out(block_out), .word_count(word_count));

  msg_block_loader #(.WORDS(4)) dut4 (
    .clock(clock), .reset_n(reset_n4), .clear(clear4), .in_valid(in_valid4),
    .in_ready(in_ready4), .in_word(in_word4), .block_valid(block_valid4),
    .block_ready(block_ready4), .block_out(block_out4), .word_count(word_count4));

  int    checks = 0;
  int    passes = 0;
  string phase  = "init";

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s/%s: got %h expected %h", phase, nm, act, exp);
  endtask

  // ---------------- reference model for WORDS=16 ----------------
  bit          m_full;
  int          m_cnt;
  logic [31:0] m_blk [16];

  task automatic m_reset();
    m_full = 0;
    m_cnt  = 0;
    for (int k = 0; k < 16; k++) m_blk[k] = '0;
  endtask

  function automatic logic [511:0] m_img();
    logic [511:0] img;
    img = '0;
    for (int k = 0; k < 16; k++) img[32*(16-k)-1 -: 32] = m_blk[k];
    return img;
  endfunction

  task automatic step16(input bit c, input bit v, input logic [31:0] w, input bit br);
    clear = c; in_valid = v; in_word = w; block_ready = br;
    @(posedge clock);
    if (c) begin
      m_full = 0; m_cnt = 0;
    end else if (!m_full && v) begin
      m_blk[m_cnt] = w;
      m_cnt++;
      if (m_cnt == 16) m_full = 1;
    end else if (m_full && br) begin
      m_full = 0; m_cnt = 0;
    end
    #1;
    chk("in_ready",    512'(in_ready),    512'(!m_full));
    chk("block_valid", 512'(block_valid), 512'(m_full));
    chk("word_count",  512'(word_count),  512'(m_cnt));
    chk("block_out",   block_out,         m_img());
  endtask

  // ---------------- table for WORDS=4 ----------------
  typedef struct {
    bit           c, v, br;
    logic [31:0]  w;
    bit           rdy, vld;
    int           cnt;
    logic [127:0] blk;
  } vec_t;

  function automatic vec_t mk(bit c, bit v, logic [31:0] w, bit br, bit rdy, bit vld, int cnt,
                              logic [31:0] b0, logic [31:0] b1, logic [31:0] b2, logic [31:0] b3);
    vec_t t;
    t.c = c; t.v = v; t.w = w; t.br = br;
    t.rdy = rdy; t.vld = vld; t.cnt = cnt;
    t.blk = {b0, b1, b2, b3};
    return t;
  endfunction

  task automatic step4(input bit c, input bit v, input logic [31:0] w, input bit br);
    clear4 = c; in_valid4 = v; in_word4 = w; block_ready4 = br;
    @(posedge clock);
    #1;
  endtask

  vec_t tbl [15];
  logic [511:0] exp_blk;

  initial begin
    reset_n  = 0; clear  = 0; in_valid  = 0; in_word  = '0; block_ready  = 0;
    reset_n4 = 0; clear4 = 0; in_valid4 = 0; in_word4 = '0; block_ready4 = 0;
    m_reset();
    #12;
    phase = "reset";
    chk("in_ready",    512'(in_ready),    512'(1));
    chk("block_valid", 512'(block_valid), 512'(0));
    chk("word_count",  512'(word_count),  512'(0));
    chk("block_out",   block_out,         '0);
    chk("in_ready4",   512'(in_ready4),   512'(1));
    chk("block_out4",  512'(block_out4),  '0);
    reset_n = 1; reset_n4 = 1;

    // ---- WORDS=4 table: gaps, FILL-ignored ready, hold, release, clears ----
    tbl[0]  = mk(0,1,32'hA1,0, 1,0,1, 32'hA1,0,0,0);
    tbl[1]  = mk(0,0,32'hFF,0, 1,0,1, 32'hA1,0,0,0);
    tbl[2]  = mk(0,1,32'hA2,1, 1,0,2, 32'hA1,32'hA2,0,0);
    tbl[3]  = mk(0,1,32'hA3,0, 1,0,3, 32'hA1,32'hA2,32'hA3,0);
    tbl[4]  = mk(0,1,32'hA4,0, 0,1,4, 32'hA1,32'hA2,32'hA3,32'hA4);
    tbl[5]  = mk(0,1,32'hA5,0, 0,1,4, 32'hA1,32'hA2,32'hA3,32'hA4);
    tbl[6]  = mk(0,0,32'h0, 1, 1,0,0, 32'hA1,32'hA2,32'hA3,32'hA4);
    tbl[7]  = mk(0,1,32'hA6,0, 1,0,1, 32'hA6,32'hA2,32'hA3,32'hA4);
    tbl[8]  = mk(1,1,32'hA7,0, 1,0,0, 32'hA6,32'hA2,32'hA3,32'hA4);
    tbl[9]  = mk(0,1,32'h01,0, 1,0,1, 32'h01,32'hA2,32'hA3,32'hA4);
    tbl[10] = mk(0,1,32'h02,0, 1,0,2, 32'h01,32'h02,32'hA3,32'hA4);
    tbl[11] = mk(0,1,32'h03,0, 1,0,3, 32'h01,32'h02,32'h03,32'hA4);
    tbl[12] = mk(0,1,32'h04,0, 0,1,4, 32'h01,32'h02,32'h03,32'h04);
    tbl[13] = mk(1,0,32'h0, 1, 1,0,0, 32'h01,32'h02,32'h03,32'h04);
    tbl[14] = mk(0,0,32'h0, 0, 1,0,0, 32'h01,32'h02,32'h03,32'h04);
    phase = "table4";
    for (int i = 0; i < 15; i++) begin
      step4(tbl[i].c, tbl[i].v, tbl[i].w, tbl[i].br);
      chk($sformatf("rdy[%0d]", i), 512'(in_ready4),    512'(tbl[i].rdy));
      chk($sformatf("vld[%0d]", i), 512'(block_valid4), 512'(tbl[i].vld));
      chk($sformatf("cnt[%0d]", i), 512'(word_count4),  512'(tbl[i].cnt));
      chk($sformatf("blk[%0d]", i), 512'(block_out4),   512'(tbl[i].blk));
    end

    // ---- WORDS=4 async reset mid-fill ----
    phase = "areset4";
    step4(0, 1, 32'hB1, 0);
    step4(0, 1, 32'hB2, 0);
    in_valid4 = 1; in_word4 = 32'hB3;
    #3 reset_n4 = 0;
    #1;
    chk("rdy",   512'(in_ready4),    512'(1));
    chk("vld",   512'(block_valid4), 512'(0));
    chk("cnt",   512'(word_count4),  512'(0));
    chk("blk",   512'(block_out4),   '0);
    #2 reset_n4 = 1; in_valid4 = 0;
    step4(0, 1, 32'h11, 0);
    step4(0, 1, 32'h22, 0);
    step4(0, 1, 32'h33, 0);
    chk("vld_early", 512'(block_valid4), 512'(0));
    step4(0, 1, 32'h44, 0);
    chk("vld",   512'(block_valid4), 512'(1));
    chk("rdy",   512'(in_ready4),    512'(0));
    chk("cnt",   512'(word_count4),  512'(4));
    chk("blk",   512'(block_out4),   512'({32'h11, 32'h22, 32'h33, 32'h44}));
    step4(0, 0, 32'h0, 1);
    chk("released", 512'(block_valid4), 512'(0));

    // ---- back-to-back fill ----
    phase = "b2b";
    for (int i = 0; i < 16; i++) step16(0, 1, 32'(i), 0);
    chk("vld",   512'(block_valid), 512'(1));
    chk("w0",    512'(block_out[511:480]), 512'(32'h0));
    chk("w15",   512'(block_out[31:0]),    512'(32'hF));
    chk("rdy",   512'(in_ready),   512'(0));
    chk("cnt",   512'(word_count), 512'(16));

    // ---- backpressure hold ----
    phase = "hold";
    exp_blk = '0;
    for (int k = 0; k < 16; k++) exp_blk[32*(16-k)-1 -: 32] = 32'(k);
    for (int i = 0; i < 10; i++) step16(0, 1, 32'hDEADBEEF, 0);
    chk("blk", block_out, exp_blk);
    chk("cnt", 512'(word_count), 512'(16));
    step16(0, 0, 32'h0, 1);
    chk("vld", 512'(block_valid), 512'(0));
    chk("rdy", 512'(in_ready),    512'(1));
    chk("cnt", 512'(word_count),  512'(0));

    // ---- gapped input ----
    phase = "gapped";
    for (int i = 0; i < 32; i++) begin
      step16(0, (i % 2) == 0, 32'h100 + 32'(i / 2), 0);
      if (i == 29) chk("vld_early", 512'(block_valid), 512'(0));
      if (i == 30) chk("vld", 512'(block_valid), 512'(1));
    end
    for (int k = 0; k < 16; k++)
      chk($sformatf("slot%0d", k), 512'(block_out[32*(16-k)-1 -: 32]), 512'(32'h100 + 32'(k)));
    chk("cnt", 512'(word_count), 512'(16));
    step16(0, 0, 32'h0, 1);

    // ---- clear mid-fill ----
    phase = "clear_fill";
    for (int i = 0; i < 5; i++) step16(0, 1, 32'h5000 + 32'(i), 0);
    step16(1, 1, 32'h5005, 0);
    chk("cnt", 512'(word_count), 512'(0));
    chk("rdy", 512'(in_ready),   512'(1));
    for (int i = 0; i < 16; i++) step16(0, 1, 32'h7000 + 32'(i), 0);
    for (int k = 0; k < 16; k++)
      chk($sformatf("slot%0d", k), 512'(block_out[32*(16-k)-1 -: 32]), 512'(32'h7000 + 32'(k)));
    chk("vld", 512'(block_valid), 512'(1));

    // ---- clear together with release ----
    phase = "clear_rel";
    step16(1, 0, 32'h0, 1);
    chk("vld", 512'(block_valid), 512'(0));
    chk("cnt", 512'(word_count),  512'(0));
    for (int i = 0; i < 3; i++) begin
      step16(0, 0, 32'h0, 1);
      chk("no_vld", 512'(block_valid), 512'(0));
    end

    // ---- async reset during word 9 ----
    phase = "areset16";
    for (int i = 0; i < 8; i++) step16(0, 1, 32'h900 + 32'(i), 0);
    in_valid = 1; in_word = 32'h908;
    #3 reset_n = 0;
    #1;
    m_reset();
    chk("rdy", 512'(in_ready),    512'(1));
    chk("vld", 512'(block_valid), 512'(0));
    chk("cnt", 512'(word_count),  512'(0));
    chk("blk", block_out,         '0);
    #2 reset_n = 1; in_valid = 0;
    for (int i = 0; i < 16; i++) step16(0, 1, 32'hC00 + 32'(i), 0);
    chk("vld", 512'(block_valid), 512'(1));
    chk("w0",  512'(block_out[511:480]), 512'(32'hC00));
    chk("w15", 512'(block_out[31:0]),    512'(32'hC0F));
    step16(0, 0, 32'h0, 1);

    // ---- randomized against the model ----
    phase = "random";
    for (int i = 0; i < 800; i++)
      step16($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
             $urandom, $urandom_range(0, 2) == 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
